spike_vote_collector: RTL and testbench
=======================================

SPIKE_VOTE_COLLECTOR -- requirements
Module: spike_vote_collector

Interface
REQ-001 The block SHALL have parameter NUM_OUTPUT, default 250, giving the number of output neurons (valid packet_out values 0..NUM_OUTPUT-1).
REQ-002 The block SHALL have parameter NUM_CLASSES, default 10, giving the number of vote classes; neuron n votes for class n mod NUM_CLASSES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port packet_out, input, 8 bits: output-neuron index from the network grid.
REQ-006 The block SHALL have port packet_out_valid, input, 1 bit: packet_out is valid this cycle.
REQ-007 The block SHALL have port cores_done, input, 1 bit: level from the grid; its rising edge closes the current picture.
REQ-008 The block SHALL have port result_vector, output, NUM_OUTPUT bits: spike vector of the last scored picture; neuron n at bit NUM_OUTPUT-1-n.
REQ-009 The block SHALL have port result_class, output, 4 bits: winning class of the last scored picture.
REQ-010 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse when result_class/result_vector update.
REQ-011 The block SHALL have port picture_count, output, 16 bits: number of pictures scored, wraps modulo 2^16.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in SCORE or ARGMAX.
REQ-013 The block SHALL have port range_error, output, 1 bit: sticky; a valid packet_out >= NUM_OUTPUT was seen.
REQ-014 The block SHALL have port overrun_error, output, 1 bit: sticky; a cores_done rising edge occurred while busy.

Function
REQ-015 The block SHALL keep a working vector; a valid packet with packet_out < NUM_OUTPUT SHALL set bit NUM_OUTPUT-1-packet_out on the next edge; duplicate spikes SHALL leave it set.
REQ-016 A valid packet with packet_out >= NUM_OUTPUT SHALL be ignored and SHALL set range_error.
REQ-017 The block SHALL register cores_done and detect a rising edge as cores_done=1 and the registered value=0.
REQ-018 On a rising edge in IDLE, the block SHALL copy the working vector, including any spike valid in that same cycle, into a snapshot register, clear the working vector, clear all class counters, and enter SCORE.
REQ-019 The state machine SHALL have states IDLE, SCORE, ARGMAX and DONE; reset state is IDLE.
REQ-020 In SCORE, the block SHALL visit neuron index k = 0..NUM_OUTPUT-1, one per cycle, incrementing counter[k mod NUM_CLASSES] when the snapshot bit for k is set; it SHALL move to ARGMAX after k = NUM_OUTPUT-1.
REQ-021 Class counters SHALL be ceil(log2(ceil(NUM_OUTPUT/NUM_CLASSES)+1)) bits wide (5 bits at defaults) and SHALL never overflow.
REQ-022 In ARGMAX, the block SHALL scan classes 0..NUM_CLASSES-1, one per cycle, replacing the best only on a strictly greater count; ties therefore resolve to the lowest index, and an all-zero picture yields class 0.
REQ-023 In DONE, for exactly one cycle, the block SHALL drive result_valid=1, load result_class and result_vector from the snapshot, increment picture_count, and then return to IDLE.
REQ-024 result_valid SHALL rise exactly NUM_OUTPUT+NUM_CLASSES+1 cycles after the edge that samples the cores_done rising edge (261 at defaults).
REQ-025 Spikes arriving while busy SHALL accumulate into the working vector for the next picture.
REQ-026 A cores_done rising edge while busy or in DONE SHALL set overrun_error, clear the working vector, and discard that picture; scoring of the current picture SHALL continue.
REQ-027 result_class and result_vector SHALL hold their values between result_valid pulses.

Reset
REQ-028 Asserting rst low SHALL, asynchronously, set the state to IDLE and zero the working vector, snapshot, counters, result_vector, result_class, result_valid, picture_count, busy, range_error, overrun_error and the registered cores_done.
REQ-029 Reset mid-SCORE SHALL abandon the picture with no result_valid; the first rising edge after release SHALL start a fresh picture.

Verification
REQ-030 Spikes 3, 13 and 23, then a cores_done rise -> result_class=3 and result_vector bits 246, 236 and 226 set, 261 cycles later; picture_count=1.
REQ-031 Spikes 2 and 5 (one vote each for classes 2 and 5), then cores_done -> result_class=2 (tie resolved to the lower index).
REQ-032 No spikes, then cores_done -> result_class=0, result_vector all zero, result_valid pulses exactly once.
REQ-033 packet_out=250 valid -> range_error=1 and the vector unchanged; a spike valid in the same cycle as the cores_done rise appears in that picture's result.
REQ-034 A second cores_done rise 100 cycles into SCORE -> overrun_error=1, the first picture's result is correct, and no second result_valid.
REQ-035 rst low at SCORE cycle 50 -> all outputs 0 immediately; a new picture with spike 7 -> result_class=7.

Source files
------------

// File: rtl/spike_vote_collector.sv
// rtl/spike_vote_collector.sv - collects output-neuron spikes per picture and votes a winning class
//
// Purpose:
//   Accumulates output-neuron spikes into a working vector. The rising edge of
//   cores_done closes the picture. The picture is then scored: each neuron n
//   votes for class n mod NUM_CLASSES, and the class with the most votes wins.
//   Ties go to the lowest class index.
//
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-low reset
//   packet_out       - output-neuron index (valid 0..NUM_OUTPUT-1)
//   packet_out_valid - packet_out qualifier
//   cores_done       - level from the grid; its rising edge closes a picture
//   result_vector    - spike vector of the last scored picture (neuron n at bit NUM_OUTPUT-1-n)
//   result_class     - winning class of the last scored picture
//   result_valid     - one-cycle pulse when the results update
//   picture_count    - pictures scored, wraps modulo 2^16
//   busy             - high while scoring or running the argmax
//   range_error      - sticky: valid packet_out >= NUM_OUTPUT seen
//   overrun_error    - sticky: cores_done rose while a picture was still in flight

module spike_vote_collector #(
  parameter int NUM_OUTPUT  = 250,
  parameter int NUM_CLASSES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            packet_out,
  input  logic                  packet_out_valid,
  input  logic                  cores_done,
  output logic [NUM_OUTPUT-1:0] result_vector,
  output logic [3:0]            result_class,
  output logic                  result_valid,
  output logic [15:0]           picture_count,
  output logic                  busy,
  output logic                  range_error,
  output logic                  overrun_error
);

  // Counters are sized for the largest possible vote count of one class, so
  // they cannot overflow.
  localparam int PER_CLASS = (NUM_OUTPUT + NUM_CLASSES - 1) / NUM_CLASSES;
  localparam int CW        = $clog2(PER_CLASS + 1);
  localparam int KW        = $clog2(NUM_OUTPUT);

  localparam logic [KW-1:0] LAST_K   = KW'(NUM_OUTPUT - 1);
  localparam logic [3:0]    LAST_C   = 4'(NUM_CLASSES - 1);
  localparam logic [8:0]    NUM_OUT9 = 9'(NUM_OUTPUT);

  typedef enum logic [1:0] {IDLE, SCORE, ARGMAX, DONE} state_t;

  state_t                state_q;
  logic                  cd_q;
  logic [NUM_OUTPUT-1:0] work_q, work_d;
  logic [NUM_OUTPUT-1:0] snap_q, snap_d;
  logic [NUM_OUTPUT-1:0] spike_vec;
  logic [CW-1:0]         cnt_q [NUM_CLASSES];
  logic [KW-1:0]         k_q;
  logic [3:0]            cls_q;
  logic [CW-1:0]         best_cnt_q;
  logic [3:0]            best_idx_q;
  logic [NUM_OUTPUT-1:0] result_vector_q;
  logic [3:0]            result_class_q;
  logic                  result_valid_q;
  logic [15:0]           picture_count_q;
  logic                  busy_q;
  logic                  range_error_q;
  logic                  overrun_error_q;
  logic                  in_range;
  logic                  rise;

  always_comb begin
    in_range  = packet_out_valid && ({1'b0, packet_out} < NUM_OUT9);
    spike_vec = '0;
    for (int n = 0; n < NUM_OUTPUT; n++) begin
      if (in_range && packet_out == 8'(n)) spike_vec[NUM_OUTPUT-1-n] = 1'b1;
    end
    rise   = cores_done & ~cd_q;
    // The snapshot includes a spike arriving in the closing cycle. Any rise
    // empties the working vector: in IDLE the contents move to the snapshot,
    // and otherwise the overrun picture is discarded.
    snap_d = work_q | spike_vec;
    work_d = rise ? '0 : (work_q | spike_vec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cd_q            <= 1'b0;
      work_q          <= '0;
      snap_q          <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
      k_q             <= '0;
      cls_q           <= '0;
      best_cnt_q      <= '0;
      best_idx_q      <= '0;
      result_vector_q <= '0;
      result_class_q  <= '0;
      result_valid_q  <= 1'b0;
      picture_count_q <= '0;
      busy_q          <= 1'b0;
      range_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      cd_q           <= cores_done;
      work_q         <= work_d;
      result_valid_q <= 1'b0;
      if (packet_out_valid && !in_range) range_error_q <= 1'b1;
      if (rise && state_q != IDLE) overrun_error_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (rise) begin
            snap_q  <= snap_d;
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
            k_q     <= '0;
            cls_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCORE;
          end
        end

        SCORE: begin
          // cls_q tracks k mod NUM_CLASSES incrementally.
          if (snap_q[LAST_K - k_q]) cnt_q[cls_q] <= cnt_q[cls_q] + CW'(1);
          cls_q <= (cls_q == LAST_C) ? 4'd0 : cls_q + 4'd1;
          k_q   <= k_q + KW'(1);
          if (k_q == LAST_K) begin
            cls_q      <= '0;
            best_cnt_q <= '0;
            best_idx_q <= '0;
            state_q    <= ARGMAX;
          end
        end

        ARGMAX: begin
          // A strict comparison keeps the lowest index on ties. An all-zero
          // picture therefore keeps class 0.
          if (cnt_q[cls_q] > best_cnt_q) begin
            best_cnt_q <= cnt_q[cls_q];
            best_idx_q <= cls_q;
          end
          if (cls_q == LAST_C) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cls_q <= cls_q + 4'd1;
          end
        end

        DONE: begin
          result_valid_q  <= 1'b1;
          result_class_q  <= best_idx_q;
          result_vector_q <= snap_q;
          picture_count_q <= picture_count_q + 16'd1;
          state_q         <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_vector = result_vector_q;
  assign result_class  = result_class_q;
  assign result_valid  = result_valid_q;
  assign picture_count = picture_count_q;
  assign busy          = busy_q;
  assign range_error   = range_error_q;
  assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_spike_vote_collector.sv
// tb/tb_spike_vote_collector.sv - self-checking bench for spike_vote_collector

module tb_spike_vote_collector;

  localparam int N = 250;
  localparam int C = 10;
  localparam int LAT = N + C + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   packet_out = '0;
  logic         packet_out_valid = 1'b0;
  logic         cores_done = 1'b0;
  logic [N-1:0] result_vector;
  logic [3:0]   result_class;
  logic         result_valid;
  logic [15:0]  picture_count;
  logic         busy;
  logic         range_error;
  logic         overrun_error;

  int checks = 0;
  int errors = 0;
  int pic_exp = 0;
  logic [N-1:0] model_vec = '0;

  spike_vote_collector #(.NUM_OUTPUT(N), .NUM_CLASSES(C)) dut (
    .clk(clk), .rst(rst), .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .cores_done(cores_done), .result_vector(result_vector), .result_class(result_class),
    .result_valid(result_valid), .picture_count(picture_count), .busy(busy),
    .range_error(range_error), .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: neuron n votes for class n % C; the first class with the
  // highest vote total wins.
  function automatic int model_class(input logic [N-1:0] v);
    int cnt [C];
    int best;
    for (int c = 0; c < C; c++) cnt[c] = 0;
    for (int n = 0; n < N; n++) if (v[N-1-n]) cnt[n % C]++;
    best = 0;
    for (int c = 1; c < C; c++) if (cnt[c] > cnt[best]) best = c;
    return best;
  endfunction

  task automatic model_add(input int n);
    if (n < N) model_vec[N-1-n] = 1'b1;
  endtask

  task automatic send_spike(input int n);
    packet_out = 8'(n);
    packet_out_valid = 1'b1;
    model_add(n);
    tick();
    packet_out_valid = 1'b0;
  endtask

  // Closes the current picture and checks the latency and the result.
  // ov_at  > 0: cores_done rises again that many cycles into scoring.
  // bb_spike >= 0: that spike arrives while busy and belongs to the next picture.
  task automatic close_and_check(input string name, input int ov_at, input int bb_spike);
    logic [N-1:0] exp_vec;
    int exp_cls;
    int at;
    exp_vec = model_vec;
    exp_cls = model_class(model_vec);
    model_vec = '0;
    cores_done = 1'b1;
    tick();
    cores_done = 1'b0;
    packet_out_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy got %0b want 1", name, busy);
    end
    at = 0;
    for (int i = 1; i <= LAT + 40; i++) begin
      cores_done = (i == ov_at);
      if (i == ov_at) model_vec = '0;
      if (bb_spike >= 0 && i == 5) begin
        packet_out = 8'(bb_spike);
        packet_out_valid = 1'b1;
        model_add(bb_spike);
      end else begin
        packet_out_valid = 1'b0;
      end
      tick();
      if (result_valid === 1'b1) begin
        at = i;
        break;
      end
    end
    cores_done = 1'b0;
    packet_out_valid = 1'b0;
    pic_exp = (pic_exp + 1) % 65536;
    checks++;
    if (at != LAT) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, at, LAT);
    end
    checks++;
    if (result_class !== 4'(exp_cls)) begin
      errors++;
      $display("FAIL %s_class got %0d want %0d", name, result_class, exp_cls);
    end
    checks++;
    if (result_vector !== exp_vec) begin
      errors++;
      $display("FAIL %s_vector got %h want %h", name, result_vector, exp_vec);
    end
    checks++;
    if (picture_count !== 16'(pic_exp)) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, picture_count, pic_exp);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result_class !== 4'(exp_cls)) begin
      errors++;
      $display("FAIL %s_pulse_hold got valid=%0b class=%0d want valid=0 class=%0d",
               name, result_valid, result_class, exp_cls);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (result_vector !== '0 || result_class !== 4'd0 || result_valid !== 1'b0 ||
        picture_count !== 16'd0 || busy !== 1'b0 || range_error !== 1'b0 || overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got cls=%0d v=%0b cnt=%0d busy=%0b rerr=%0b oerr=%0b want all 0",
               result_class, result_valid, picture_count, busy, range_error, overrun_error);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_spike(3);
    send_spike(13);
    send_spike(23);
    close_and_check("basic", 0, -1);
    checks++;
    if (result_vector[246] !== 1'b1 || result_vector[236] !== 1'b1 || result_vector[226] !== 1'b1) begin
      errors++;
      $display("FAIL basic_bits got %0b%0b%0b want 111",
               result_vector[246], result_vector[236], result_vector[226]);
    end
  endtask

  task automatic test_tie();
    send_spike(5);
    send_spike(2);
    send_spike(5);
    close_and_check("tie", 0, -1);
  endtask

  task automatic test_empty();
    close_and_check("empty", 0, -1);
  endtask

  task automatic test_range_same_cycle();
    send_spike(250);
    checks++;
    if (range_error !== 1'b1) begin
      errors++;
      $display("FAIL range_error got %0b want 1", range_error);
    end
    send_spike(40);
    packet_out = 8'd17;
    packet_out_valid = 1'b1;
    model_add(17);
    close_and_check("same_cycle", 0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      int cnt;
      cnt = int'($urandom_range(0, 14));
      for (int j = 0; j < cnt; j++) send_spike(int'($urandom_range(0, N - 1)));
      close_and_check("random", 0, -1);
    end
  endtask

  task automatic test_back_to_back();
    send_spike(21);
    send_spike(31);
    send_spike(40);
    close_and_check("b2b_first", 0, 48);
    close_and_check("b2b_second", 0, -1);
  endtask

  task automatic test_overrun();
    int pulses;
    send_spike(4);
    send_spike(14);
    send_spike(9);
    close_and_check("overrun_first", 100, -1);
    checks++;
    if (overrun_error !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %0b want 1", overrun_error);
    end
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (result_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_second got pulses=%0d busy=%0b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_reset_mid_score();
    send_spike(3);
    cores_done = 1'b1;
    tick();
    cores_done = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (result_vector !== '0 || result_class !== 4'd0 || result_valid !== 1'b0 ||
        picture_count !== 16'd0 || busy !== 1'b0 || range_error !== 1'b0 || overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got cls=%0d cnt=%0d busy=%0b rerr=%0b oerr=%0b want all 0",
               result_class, picture_count, busy, range_error, overrun_error);
    end
    model_vec = '0;
    pic_exp = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    send_spike(7);
    close_and_check("after_reset", 0, -1);
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_tie();
    test_empty();
    test_range_same_cycle();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid_score();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
